morse_sequencer: RTL



---
 rtl/morse_pkg.sv | 68 ++++++
 rtl/morse_tick_gen.sv | 55 +++++
 rtl/morse_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter sequencer.
// Holds the controller state encoding, the on/off pattern ROM for letters A-H
// and lookup functions returning each letter's pattern and length in units.
// Patterns are sent LSB first: 1 = lamp on, dot = 1 unit, dash = 3 units,
// with a 1-unit off gap between symbols inside a letter.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [15:0] PAT_A = 16'h001D;
  localparam logic [15:0] PAT_B = 16'h0157;
  localparam logic [15:0] PAT_C = 16'h05D7;
  localparam logic [15:0] PAT_D = 16'h0057;
  localparam logic [15:0] PAT_E = 16'h0001;
  localparam logic [15:0] PAT_F = 16'h0175;
  localparam logic [15:0] PAT_G = 16'h0177;
  localparam logic [15:0] PAT_H = 16'h0055;

  localparam logic [3:0] LEN_A = 4'd5;
  localparam logic [3:0] LEN_B = 4'd9;
  localparam logic [3:0] LEN_C = 4'd11;
  localparam logic [3:0] LEN_D = 4'd7;
  localparam logic [3:0] LEN_E = 4'd1;
  localparam logic [3:0] LEN_F = 4'd9;
  localparam logic [3:0] LEN_G = 4'd9;
  localparam logic [3:0] LEN_H = 4'd7;

  // Unit pattern of the selected letter (0=A ... 7=H).
  function automatic logic [15:0] morse_pattern(input logic [2:0] sel);
    logic [15:0] pat_s;
    case (sel)
      3'd0:    pat_s = PAT_A;
      3'd1:    pat_s = PAT_B;
      3'd2:    pat_s = PAT_C;
      3'd3:    pat_s = PAT_D;
      3'd4:    pat_s = PAT_E;
      3'd5:    pat_s = PAT_F;
      3'd6:    pat_s = PAT_G;
      3'd7:    pat_s = PAT_H;
      default: pat_s = 16'h0000;
    endcase
    return pat_s;
  endfunction

  // Number of pattern units of the selected letter.
  function automatic logic [3:0] morse_len(input logic [2:0] sel);
    logic [3:0] len_s;
    case (sel)
      3'd0:    len_s = LEN_A;
      3'd1:    len_s = LEN_B;
      3'd2:    len_s = LEN_C;
      3'd3:    len_s = LEN_D;
      3'd4:    len_s = LEN_E;
      3'd5:    len_s = LEN_F;
      3'd6:    len_s = LEN_G;
      3'd7:    len_s = LEN_H;
      default: len_s = 4'd1;
    endcase
    return len_s;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Unit prescaler for the Morse sequencer.
// Counts clock cycles while enabled and strobes tick for one cycle every
// TICK_DIV cycles. The strobe is decoded from the count register only.
// Ports:
//   Clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   clr    - synchronous clear of the count (dominates en)
//   en     - count enable
//   tick   - one-cycle strobe when the count equals TICK_DIV-1
module morse_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic Clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Next count: clear, wrap at the end of a unit, or advance.
  always_comb begin
    cnt_s = cnt_r;
    if (clr) begin
      cnt_s = CNT_ZERO;
    end else if (en) begin
      if (cnt_r == CNT_MAX) begin
        cnt_s = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/morse_sequencer.sv
// Morse letter sequencer: sends one letter (A-H) onto a single LED.
// A start request in IDLE latches sel; the letter pattern is loaded, shifted
// out one unit per prescaled tick, followed by GAP_UNITS off units, then a
// one-cycle done pulse. With repeat_mode high at the end of the gap, sel is
// re-sampled and the letter is sent again instead of finishing. abort returns
// to IDLE from any state without a done pulse.
// Ports:
//   Clock       - system clock, rising edge
//   reset       - asynchronous, active-high
//   start       - request, sampled only in IDLE
//   sel[2:0]    - letter select 0=A .. 7=H
//   repeat_mode - re-send instead of finishing when high at end of gap
//   abort       - terminates any transmission
//   led         - Morse output, 1 = lamp on
//   busy        - high in every state except IDLE
//   done        - one-cycle pulse on normal completion
//   tick        - one-cycle unit strobe
//   cur_sel     - latched letter being sent
// All of led/busy/done/tick/cur_sel are decoded from registers only.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_UNITS = 3
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] sel,
  input  logic       repeat_mode,
  input  logic       abort,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic       tick,
  output logic [2:0] cur_sel
);

  localparam int GAP_W = $clog2(GAP_UNITS + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_UNITS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           state_r;
  state_t           state_s;
  state_t           state_fsm_s;
  logic [15:0]      shreg_r;
  logic [15:0]      shreg_s;
  logic [3:0]       bitcnt_r;
  logic [3:0]       bitcnt_s;
  logic [GAP_W-1:0] gapcnt_r;
  logic [GAP_W-1:0] gapcnt_s;
  logic [2:0]       cur_sel_r;
  logic [2:0]       cur_sel_s;
  logic             timing_s;
  logic             pre_clr_s;

  // The prescaler only runs while units are being timed; an abort also
  // clears it so the next transmission starts on a full unit.
  assign timing_s  = (state_r == SEND) || (state_r == GAP);
  assign pre_clr_s = !timing_s || abort;

  morse_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .Clock(Clock),
    .reset(reset),
    .clr  (pre_clr_s),
    .en   (timing_s),
    .tick (tick)
  );

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_fsm_s = state_r;
    shreg_s     = shreg_r;
    bitcnt_s    = bitcnt_r;
    gapcnt_s    = gapcnt_r;
    cur_sel_s   = cur_sel_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          cur_sel_s   = sel;
          state_fsm_s = LOAD;
        end else begin
          state_fsm_s = IDLE;
        end
      end
      LOAD: begin
        shreg_s     = morse_pattern(cur_sel_r);
        bitcnt_s    = morse_len(cur_sel_r);
        state_fsm_s = SEND;
      end
      SEND: begin
        if (tick) begin
          shreg_s  = {1'b0, shreg_r[15:1]};
          bitcnt_s = bitcnt_r - 4'd1;
          // bitcnt still holds the unit just finished, so 1 means last bit.
          if (bitcnt_r == 4'd1) begin
            gapcnt_s    = GAP_INIT;
            state_fsm_s = GAP;
          end else begin
            state_fsm_s = SEND;
          end
        end else begin
          state_fsm_s = SEND;
        end
      end
      GAP: begin
        if (tick) begin
          gapcnt_s = gapcnt_r - GAP_ONE;
          if (gapcnt_r == GAP_ONE) begin
            if (repeat_mode) begin
              cur_sel_s   = sel;
              state_fsm_s = LOAD;
            end else begin
              state_fsm_s = DONE;
            end
          end else begin
            state_fsm_s = GAP;
          end
        end else begin
          state_fsm_s = GAP;
        end
      end
      DONE: begin
        state_fsm_s = IDLE;
      end
      default: begin
        state_fsm_s = IDLE;
      end
    endcase

    // abort overrides every transition out of a non-IDLE state.
    if (abort && (state_r != IDLE)) begin
      state_s = IDLE;
    end else begin
      state_s = state_fsm_s;
    end
  end

  // State, shift register, counters and latched letter.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shreg_r   <= 16'h0000;
      bitcnt_r  <= 4'd0;
      gapcnt_r  <= {GAP_W{1'b0}};
      cur_sel_r <= 3'd0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bitcnt_r  <= bitcnt_s;
      gapcnt_r  <= gapcnt_s;
      cur_sel_r <= cur_sel_s;
    end
  end

  assign led     = (state_r == SEND) && shreg_r[0];
  assign busy    = (state_r != IDLE);
  assign done    = (state_r == DONE);
  assign cur_sel = cur_sel_r;

endmodule
